// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU op codes, FSM
// state encoding and the legal-op check used to flag error responses.
package alu_arbiter_pkg;

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOrr   = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpPassB = 4'b0111;
  localparam logic [3:0] OpNor   = 4'b1100;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

  // True for the op codes the ALU implements natively.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OpAnd, OpOrr, OpAdd, OpSub, OpPassB, OpNor: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/LEGv8ALU.sv
// LEGv8 integer ALU, purely combinational. Unknown op codes fall back to an
// add so callers always see a defined result.
module LEGv8ALU
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DataW = 64
) (
  input  logic [DataW-1:0] a_i,
  input  logic [DataW-1:0] b_i,
  input  logic [3:0]       alu_ctrl_i,
  output logic [DataW-1:0] result_o,
  output logic             zero_o
);

  // Op decode; arithmetic wraps modulo 2^DataW.
  always_comb begin
    result_o = a_i + b_i;
    case (alu_ctrl_i)
      OpAnd:   result_o = a_i & b_i;
      OpOrr:   result_o = a_i | b_i;
      OpAdd:   result_o = a_i + b_i;
      OpSub:   result_o = a_i - b_i;
      OpPassB: result_o = b_i;
      OpNor:   result_o = ~(a_i | b_i);
      default: result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared LEGv8ALU. One operation is in flight at
// a time: IDLE accepts, EXEC evaluates from captured operands, RESP holds the
// response until the consumer takes it.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e state_q, state_d;

  logic              any_valid;
  logic              grant_id;
  logic              accept;

  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              id_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero_unused;

  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  op_count_q;

  assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_RR_EN
  logic last_grant_q;

  // Grant selection: on contention pick the requester not served last.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = ~req0_valid;
    end
  end

  // Last-grant pointer; reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= grant_id;
    end
  end
`else
  // Grant selection: fixed priority, requester 0 always wins a tie.
  always_comb begin
    grant_id = ~req0_valid;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (any_valid) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; ready is gated by reset so nothing is accepted while it is high.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    rsp_valid  = (state_q == StResp);
    busy       = (state_q != StIdle);
    if ((state_q == StIdle) && !reset && any_valid) begin
      accept     = 1'b1;
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
  end

  // Capture the granted request so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      op_q <= grant_id ? req1_op : req0_op;
      a_q  <= grant_id ? req1_a  : req0_a;
      b_q  <= grant_id ? req1_b  : req0_b;
      id_q <= grant_id;
    end
  end

  LEGv8ALU #(
    .DataW (DATA_W)
  ) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .alu_ctrl_i (op_q),
    .result_o   (alu_result),
    .zero_o     (alu_zero_unused)
  );

  // Response registers load in EXEC and stay frozen through RESP. The zero
  // flag is derived here from the value being registered, not from the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (state_q == StExec) begin
      rsp_id_q     <= id_q;
      rsp_result_q <= alu_result;
      rsp_zero_q   <= (alu_result == '0);
      rsp_err_q    <= ~is_legal_op(op_q);
    end
  end

  // Completed-handshake counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q <= '0;
    end else if ((state_q == StResp) && rsp_ready) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a response scoreboard.
module tb_alu_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [DW-1:0] rsp_result;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  typedef struct {
    logic          id;
    logic [DW-1:0] res;
    logic          zero;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [3:0] op,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0111: e.res = b;
      4'b1100: e.res = ~(a | b);
      default: begin
        e.res = a + b;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Compare current response outputs against the oldest expected entry.
  task automatic check_front(input string tag);
    total++;
    assert (sb.size() != 0)
    else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      chk({tag, "_id"},     64'(rsp_id),     64'(sb[0].id));
      chk({tag, "_result"}, rsp_result,      sb[0].res);
      chk({tag, "_zero"},   64'(rsp_zero),   64'(sb[0].zero));
      chk({tag, "_err"},    64'(rsp_err),    64'(sb[0].err));
    end
  endtask

  task automatic pop_rsp(input string tag);
    check_front(tag);
    if (sb.size() != 0) void'(sb.pop_front());
    exp_cnt = exp_cnt + CW'(1);
  endtask

  // New data on idle request ports must not leak into the in-flight op.
  task automatic scramble();
    req0_op = 4'($urandom);
    req1_op = 4'($urandom);
    req0_a  = {$urandom, $urandom};
    req0_b  = {$urandom, $urandom};
    req1_a  = {$urandom, $urandom};
    req1_b  = {$urandom, $urandom};
  endtask

  // One isolated operation, starting from IDLE, with rsp_ready held low for hold cycles.
  task automatic do_op(input string tag, input logic id, input logic [3:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    chk({tag, "_ready"},    64'(id ? req1_ready : req0_ready), 64'd1);
    chk({tag, "_noready"},  64'(id ? req0_ready : req1_ready), 64'd0);
    sb.push_back(model(id, op, a, b));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    scramble();
    #1;
    chk({tag, "_t1_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_t1_busy"},  64'(busy),      64'd1);
    @(negedge clk);
    scramble();
    #1;
    chk({tag, "_t2_valid"}, 64'(rsp_valid), 64'd1);
    check_front({tag, "_t2"});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble();
      #1;
      chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_cnt"},   64'(op_count),  64'(exp_cnt));
      check_front({tag, "_hold"});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_hs_valid"}, 64'(rsp_valid), 64'd1);
    pop_rsp({tag, "_hs"});
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk({tag, "_post_busy"},  64'(busy),      64'd0);
    chk({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_post_cnt"},   64'(op_count),  64'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          exp_seq [4];
    logic          got_seq [4];
    int            grants;
    int            rsps;
    logic [3:0]    ops [8];
    logic [3:0]    rop;
    logic [DW-1:0] ra, rb;

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
`ifdef ALU_ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset with requests pending: nothing may be accepted.
    reset      = 1'b1;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    scramble();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_valid",  64'(rsp_valid),  64'd0);
    chk("rst_busy",   64'(busy),       64'd0);
    chk("rst_cnt",    64'(op_count),   64'd0);
    chk("rst_id",     64'(rsp_id),     64'd0);
    chk("rst_result", rsp_result,      64'd0);
    chk("rst_zero",   64'(rsp_zero),   64'd0);
    chk("rst_err",    64'(rsp_err),    64'd0);
    @(negedge clk);
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic add, subtract to zero with back-pressure, illegal op, NOR of zeros.
    do_op("add",  1'b0, 4'b0010, 64'd5, 64'd7, 0);
    chk("add_result_const", sb.size() == 0 ? 64'd12 : 64'd0, model(1'b0, 4'b0010, 64'd5, 64'd7).res);
    do_op("sub0", 1'b1, 4'b0110, 64'd9, 64'd9, 3);
    chk("sub0_cnt", 64'(op_count), 64'd2);
    do_op("illegal", 1'b1, 4'b1111, 64'd1, 64'd2, 0);
    do_op("nor",     1'b1, 4'b1100, 64'd0, 64'd0, 0);

    // Both requesters valid every cycle for four grants.
    grants = 0;
    rsps   = 0;
    for (int cyc = 0; cyc < 40 && rsps < 4; cyc++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      if (grants < 4) begin
        req0_valid = 1'b1; req0_op = 4'b0010;
        req0_a = 64'(100 + grants); req0_b = 64'(cyc);
        req1_valid = 1'b1; req1_op = 4'b0110;
        req1_a = 64'(1000 + grants); req1_b = 64'(cyc);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (grants < 4 && (req0_ready || req1_ready)) begin
        chk("sim_one_grant", 64'(req0_ready & req1_ready), 64'd0);
        got_seq[grants] = req1_ready;
        if (exp_seq[grants])
          sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
        else
          sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
        grants++;
      end
      if (rsp_valid && rsp_ready) begin
        pop_rsp("sim");
        rsps++;
      end
    end
    @(negedge clk);
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("sim_rsps",   64'(rsps), 64'd4);
    chk("sim_grants", 64'(grants), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("sim_grant%0d", i), 64'(got_seq[i]), 64'(exp_seq[i]));
    chk("sim_cnt", 64'(op_count), 64'd8);

    // Reset during EXEC drops the operation.
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 64'd1; req0_b = 64'd1;
    #1;
    chk("rx_ready", 64'(req0_ready), 64'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    reset      = 1'b1;
    #1;
    chk("rx_exec_busy", 64'(busy), 64'd1);
    chk("rx_ready1",    64'(req1_ready), 64'd0);
    @(negedge clk);
    reset      = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    #1;
    chk("rx_busy",  64'(busy),      64'd0);
    chk("rx_valid", 64'(rsp_valid), 64'd0);
    chk("rx_cnt",   64'(op_count),  64'd0);
    @(negedge clk);
    #1;
    chk("rx_valid2", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;
    exp_cnt   = '0;

    // Sixteen handshakes from reset: the 4-bit counter wraps to zero.
    do_op("after_rst", 1'b0, 4'b0110, 64'd3, 64'd5, 0);
    for (int k = 1; k < 16; k++) begin
      rop = ops[$urandom_range(0, 7)];
      ra  = {$urandom, $urandom};
      rb  = (k == 7) ? ra : {$urandom, $urandom};
      if (k == 15) chk("pre_wrap_cnt", 64'(op_count), 64'd15);
      do_op($sformatf("rnd%0d", k), 1'(k % 2), rop, ra, rb, k % 3);
    end
    chk("wrap_cnt", 64'(op_count), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
